// File: rtl/output_collector.sv
`default_nettype none
// ============================================================================
// output_collector : captures chip results into a show-ahead FIFO stream
// Revision 1.0
// ============================================================================
module output_collector #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FRAME_OUTPUTS      = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                                    clk,
  input  logic                                    arst_n_in,
  input  logic [IO_DATA_WIDTH-1:0]                con_1,
  input  logic [IO_DATA_WIDTH-1:0]                con_2,
  input  logic                                    driving_cons,
  input  logic                                    output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
  input  logic                                    running,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ACCUMULATION_WIDTH-1:0]           out_data,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   out_ch,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]         fifo_level,
  output logic [$clog2(FRAME_OUTPUTS+1)-1:0]      out_count,
  output logic                                    frame_done,
  output logic [3:0]                              err
);

  localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CHW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH+1);
  localparam int CW  = $clog2(FRAME_OUTPUTS+1);
  localparam int EW  = ACCUMULATION_WIDTH + XW + YW + CHW;

  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_OUTPUTS);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      err_q, err_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];

  logic            cap;
  logic            collect_now;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  logic [LW-1:0]   level_after_pop;
  logic [EW-1:0]   head;

  // FSM and FIFO share one process: DRAIN exit and overflow both depend on FIFO state
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    err_d           = err_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    mem_d           = mem_q;
    collect_now     = 1'b0;
    push_req        = 1'b0;
    push            = 1'b0;
    cap             = output_valid & driving_cons;
    empty           = (level_q == '0);
    full            = (level_q == DEPTH_LVL);
    pop             = ~empty & out_ready;
    level_after_pop = level_q - LW'(pop);

    if ((state_q == IDLE) && running) begin
      count_d = '0;
      err_d   = '0;
    end
    if (output_valid && !driving_cons) err_d[1] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (running) begin
          state_d     = COLLECT;
          collect_now = 1'b1;
        end else if (cap) begin
          err_d[3] = 1'b1;
        end
      end
      COLLECT: collect_now = 1'b1;
      DRAIN: begin
        if (cap) err_d[3] = 1'b1;
        if (level_after_pop == '0) state_d = DONE;
      end
      DONE: begin
        if (cap) err_d[3] = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (collect_now) begin
      if (cap) begin
        push_req = 1'b1;
        if (count_d != FRAME_CNT) count_d = count_d + CW'(1);
      end
      if (count_d == FRAME_CNT) begin
        state_d = DRAIN;
      end else if (!running) begin
        state_d  = DRAIN;
        err_d[2] = 1'b1;
      end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle
    push = push_req & (~full | pop);
    if (push_req && full && !pop) err_d[0] = 1'b1;

    if (push) begin
      mem_d[wr_ptr_q] = {con_2, con_1, output_x, output_y, output_ch};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q  <= IDLE;
      count_q  <= '0;
      err_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

  assign head       = empty ? '0 : mem_q[rd_ptr_q];
  assign out_valid  = ~empty;
  assign out_data   = head[EW-1 -: ACCUMULATION_WIDTH];
  assign out_x      = head[YW+CHW +: XW];
  assign out_y      = head[CHW +: YW];
  assign out_ch     = head[0 +: CHW];
  assign fifo_level = level_q;
  assign out_count  = count_q;
  assign frame_done = (state_q == DONE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_output_collector.sv
`default_nettype none
// ============================================================================
// tb_output_collector : randomized directed bench with a queue-based model
// Revision 1.0
// ============================================================================
module tb_output_collector;

  logic        clk;
  logic        arst_n_in;
  logic [15:0] con_1, con_2;
  logic        driving_cons, output_valid, running, out_ready;
  logic [1:0]  output_x, output_y;
  logic [0:0]  output_ch;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_x, out_y;
  logic [0:0]  out_ch;
  logic [2:0]  fifo_level;
  logic [5:0]  out_count;
  logic        frame_done;
  logic [3:0]  err;

  output_collector #(
    .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(32),
    .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4), .OUTPUT_NB_CHANNELS(2),
    .FRAME_OUTPUTS(32), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .con_1(con_1), .con_2(con_2),
    .driving_cons(driving_cons), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
    .running(running), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
    .fifo_level(fifo_level), .out_count(out_count),
    .frame_done(frame_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_done = 0;

  // Reference model: queue of buffered entries, frame phase, count and sticky flags
  logic [36:0] mq[$];
  int          m_phase = 0;  // 0 idle, 1 collecting, 2 draining, 3 frame finished
  int          m_count = 0;
  logic [3:0]  m_err   = 4'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  function automatic logic [36:0] rnd();
    return {32'($urandom), 5'($urandom)};
  endfunction

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("out_count", 64'(out_count), 64'(m_count));
    chk("err", 64'(err), 64'(m_err));
    chk("frame_done", 64'(frame_done), 64'(m_phase == 3));
    if (mq.size() > 0) chk("head", 64'({out_data, out_x, out_y, out_ch}), 64'(mq[0]));
    if (frame_done) n_done++;
  endtask

  task automatic cycle(input bit v, input bit d, input bit rdy, input bit run, input logic [36:0] ent);
    int ph;
    bit cap, pop, coll;
    output_valid = v;
    driving_cons = d;
    {con_2, con_1, output_x, output_y, output_ch} = ent;
    out_ready = rdy;
    running   = run;
    @(posedge clk);
    ph   = m_phase;
    cap  = v && d;
    pop  = (mq.size() > 0) && rdy;
    coll = 0;
    if (ph == 0 && run) begin
      m_err   = 4'b0;
      m_count = 0;
    end
    if (v && !d) m_err[1] = 1'b1;
    case (ph)
      0: if (run) begin m_phase = 1; coll = 1; end else if (cap) m_err[3] = 1'b1;
      1: coll = 1;
      2: if (cap) m_err[3] = 1'b1;
      default: begin if (cap) m_err[3] = 1'b1; m_phase = 0; end
    endcase
    if (pop) void'(mq.pop_front());
    if (coll) begin
      if (cap) begin
        if (m_count < 32) m_count++;
        if (mq.size() < 4) mq.push_back(ent); else m_err[0] = 1'b1;
      end
      if (m_count == 32) m_phase = 2;
      else if (!run) begin m_phase = 2; m_err[2] = 1'b1; end
    end
    if (ph == 2 && mq.size() == 0) m_phase = 3;
    #1;
    check_all();
  endtask

  task automatic drain(input int cycles, input bit random_ready);
    for (int k = 0; k < cycles; k++)
      cycle(0, 1, random_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 0, rnd());
  endtask

  initial begin
    int d0, ncap;
    arst_n_in = 1'b0;
    output_valid = 0; driving_cons = 0; running = 0; out_ready = 0;
    {con_2, con_1, output_x, output_y, output_ch} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'({out_data, out_x, out_y, out_ch}), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_count", 64'(out_count), 0);
    chk("rst_done", 64'(frame_done), 0);
    chk("rst_err", 64'(err), 0);
    arst_n_in = 1'b1;

    // Full frame: capture on the IDLE->COLLECT edge counts as result 0
    d0 = n_done;
    for (int i = 0; i < 32; i++)
      cycle(1, 1, 1, 1, {32'h0001_0000 + 32'(i), 2'(i % 4), 2'((i / 4) % 4), 1'(i / 16)});
    chk("f1_count", 64'(out_count), 32);
    drain(8, 0);
    chk("f1_done_pulses", 64'(n_done - d0), 1);
    chk("f1_err", 64'(err), 0);

    // Back-pressure, push-with-pop on full, overflow, bus ownership, early stop
    d0 = n_done;
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1, rnd());
    chk("bp_level_full", 64'(fifo_level), 4);
    chk("bp_err_none", 64'(err), 0);
    cycle(1, 1, 1, 1, rnd());
    chk("bp_push_pop_err0", 64'(err[0]), 0);
    chk("bp_push_pop_level", 64'(fifo_level), 4);
    cycle(1, 1, 0, 1, rnd());
    chk("bp_overflow_err0", 64'(err[0]), 1);
    cycle(1, 0, 0, 1, rnd());
    chk("drive_err1", 64'(err[1]), 1);
    chk("drive_level", 64'(fifo_level), 4);
    cycle(0, 1, 0, 0, rnd());
    chk("bp_early_err2", 64'(err[2]), 1);
    drain(10, 0);
    chk("bp_done_pulses", 64'(n_done - d0), 1);

    // Early stop after 10 captures with random gaps and ready
    d0 = n_done;
    ncap = 0;
    for (int k = 0; k < 200 && ncap < 10; k++) begin
      bit v;
      v = ($urandom_range(0, 2) != 0);
      cycle(v, 1, ($urandom_range(0, 3) != 0), 1, rnd());
      if (v) ncap++;
    end
    chk("es_captures", 64'(ncap), 10);
    cycle(0, 1, 1, 0, rnd());
    chk("es_err2", 64'(err[2]), 1);
    drain(30, 1);
    drain(10, 0);
    chk("es_done_pulses", 64'(n_done - d0), 1);

    // Stray capture in IDLE, then a new frame clears the flags
    cycle(1, 1, 1, 0, rnd());
    chk("stray_err3", 64'(err[3]), 1);
    chk("stray_level", 64'(fifo_level), 0);
    cycle(0, 1, 1, 1, rnd());
    chk("start_err_clear", 64'(err), 0);
    chk("start_count_clear", 64'(out_count), 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, rnd());

    // Asynchronous reset mid-cycle with three buffered entries
    #2;
    arst_n_in = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_level", 64'(fifo_level), 0);
    chk("arst_count", 64'(out_count), 0);
    mq.delete();
    m_phase = 0; m_count = 0; m_err = 4'b0;
    output_valid = 0; running = 0;
    repeat (2) @(posedge clk);
    #1;
    arst_n_in = 1'b1;
    cycle(1, 1, 1, 0, rnd());
    chk("arst_idle_stray", 64'(err[3]), 1);

    // Randomized full frame
    d0 = n_done;
    ncap = 0;
    for (int k = 0; k < 400 && m_phase != 2; k++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      cycle(v, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), 1, rnd());
    end
    chk("rf_count", 64'(out_count), 32);
    drain(30, 1);
    drain(10, 0);
    chk("rf_done_pulses", 64'(n_done - d0), 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_collector.md
# output_collector

System-side capture stage directly downstream of `top_chip`, instantiated next to it in the system wrapper. When the chip drives the shared connections (`driving_cons`) and asserts `output_valid`, the collector samples one accumulation result from `{con_2, con_1}` together with its `(x, y, ch)` coordinates. It buffers each sample in a FIFO and re-emits it on a valid/ready stream toward the external result memory or the checker. It also counts results per frame and raises sticky protocol and error flags, because the chip output has no back-pressure path.

## Interface
- IO_DATA_WIDTH, 16: width of each con bus.
- ACCUMULATION_WIDTH, 32: result width; must equal 2*IO_DATA_WIDTH.
- FEATURE_MAP_WIDTH, 1024: x range.
- FEATURE_MAP_HEIGHT, 1024: y range.
- OUTPUT_NB_CHANNELS, 64: ch range.
- FRAME_OUTPUTS, FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS: results expected per frame.
- FIFO_DEPTH, 8: entries; power of two, at least 2.

Ports:
- clk  in  1  single clock.
- arst_n_in  in  1  reset; asynchronous, active-low.
- con_1  in  IO_DATA_WIDTH  result low half; observed only, never driven.
- con_2  in  IO_DATA_WIDTH  result high half; observed only, never driven.
- driving_cons  in  1  chip owns the con buses.
- output_valid  in  1  chip result-valid strobe.
- output_x  in  $clog2(FEATURE_MAP_WIDTH)  result x coordinate.
- output_y  in  $clog2(FEATURE_MAP_HEIGHT)  result y coordinate.
- output_ch  in  $clog2(OUTPUT_NB_CHANNELS)  result channel.
- running  in  1  chip busy flag.
- out_valid  out  1  stream entry available.
- out_ready  in  1  downstream accepts the entry.
- out_data  out  ACCUMULATION_WIDTH  buffered result.
- out_x, out_y, out_ch  out  same widths as inputs  buffered coordinates.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- out_count  out  $clog2(FRAME_OUTPUTS+1)  results captured in the current frame.
- frame_done  out  1  one-cycle pulse at end of frame.
- err  out  4  sticky flags: [0] overflow, [1] drive_error, [2] incomplete, [3] stray.

## Operation
- Capture condition: `cap = output_valid & driving_cons`. The entry is {con_2, con_1, output_x, output_y, output_ch}.
- `output_valid & ~driving_cons`: nothing is captured, and err[1] is set.
- State machine: IDLE, COLLECT, DRAIN, DONE.
  - IDLE → COLLECT when `running` = 1. Entering COLLECT clears out_count and err.
  - COLLECT: each `cap` pushes one entry and increments out_count.
  - COLLECT → DRAIN when out_count reaches FRAME_OUTPUTS; the capture that reaches the limit is pushed.
  - COLLECT → DRAIN when `running` falls while out_count < FRAME_OUTPUTS; this sets err[2].
  - DRAIN: a `cap` is dropped and sets err[3]. DRAIN → DONE when the FIFO is empty.
  - DONE: frame_done = 1 for exactly one cycle, then → IDLE.
- In IDLE, a `cap` is dropped and sets err[3].
- FIFO is show-ahead: out_valid = ~empty, and out_* always present the head entry. A pop happens when `out_valid & out_ready`.
- FIFO boundary rules:
  - Push while full with a simultaneous pop: accepted, level unchanged.
  - Push while full with no pop: data dropped, err[0] set, level unchanged.
  - Pop while empty: impossible, because out_valid = 0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- out_count saturates at FRAME_OUTPUTS.
- Sticky err bits clear only on reset or on entry to COLLECT.
- Reset mid-frame: all state is discarded and the FIFO is emptied; there is no recovery of the partial frame.

## Timing
- Reset values:
  - state = IDLE.
  - out_valid = 0, out_data, out_x, out_y, out_ch = 0.
  - fifo_level = 0, out_count = 0.
  - frame_done = 0, err = 0.
- Inputs are sampled on the rising clk edge. A capture at edge N appears as out_valid = 1 and fifo_level incremented after edge N, so latency from capture to stream is 1 cycle.
- A pop at edge N exposes the next entry after edge N.
- Back-to-back captures are sustained at 1 per cycle.
- IDLE→COLLECT happens at the edge where running = 1. A `cap` in that same cycle is counted.
- frame_done asserts the cycle after the last entry is popped.

## Test plan
Bench parameters: W = H = 4, OC = 2, FRAME_OUTPUTS = 32, FIFO_DEPTH = 4.

- Full-frame stream: running = 1, 32 captures with data = 0x0001_0000+i, out_ready = 1 → 32 stream entries in order with matching x/y/ch; out_count = 32; one frame_done pulse; err = 0.
- Back-pressure: out_ready = 0 and 4 captures → fifo_level = 4, err = 0. A 5th capture → err[0] = 1 and entries 0..3 intact. 5th capture with a simultaneous pop → accepted, err[0] stays 0.
- Bus ownership: output_valid = 1 with driving_cons = 0 → no push, err[1] = 1, fifo_level unchanged.
- Early stop: running falls after 10 captures → DRAIN, err[2] = 1; frame_done is asserted once all 10 entries have been popped.
- Stray result: a capture while in IDLE → dropped, err[3] = 1. Next running = 1 → err cleared and out_count = 0.
- Reset mid-frame: arst_n_in low with 3 entries buffered → out_valid = 0, fifo_level = 0 and state = IDLE, asynchronously before the next clk edge.
